mcpu_bus_unit: RTL and testbench

//  Parametrised load/store bus unit for the multi-cycle CPU. It sits between the control/datapath

---
 rtl/mcpu_bus_pkg.sv | 23 ++
 rtl/mcpu_lane_align.sv | 55 +++++
 rtl/mcpu_bus_unit.sv | 136 +++++++++++++
 tb/tb_mcpu_bus_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_bus_pkg.sv
// Shared types for the multi-cycle CPU load/store bus unit.
// Holds the access size codes, the FSM state encoding and the size-to-bytes helper.
package mcpu_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        ERR    = 2'b11
    } state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mcpu_lane_align.sv
// Combinational lane steering: byte enables, store-data replication across lanes,
// and load-data right-justification with sign or zero extension.
module mcpu_lane_align
    import mcpu_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(DATA_W / 8),
    localparam int IDX_W = $clog2(DATA_W)
)(
    input  logic [1:0]        i_size,
    input  logic [OFF_W-1:0]  i_off,
    input  logic              i_sign_ext,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_din,
    output logic [NB-1:0]     o_byte_en,
    output logic [DATA_W-1:0] o_data_rep,
    output logic [DATA_W-1:0] o_load_ext
);

    logic [3:0]        w_bytes;
    logic [NB-1:0]     w_lane_mask;
    logic [DATA_W-1:0] w_shifted;
    logic [6:0]        w_fbits;
    logic [6:0]        w_fbits_c;
    logic [IDX_W-1:0]  w_msb;
    logic              w_sign;

    assign w_bytes     = size_bytes(i_size);
    assign w_lane_mask = NB'((16'd1 << w_bytes) - 16'd1);
    assign o_byte_en   = w_lane_mask << i_off;

    // Lane b carries byte (b mod bytes) of the store data; bytes is a power of two.
    always_comb begin
        o_data_rep = '0;
        for (int b = 0; b < NB; b++) begin
            o_data_rep[8*b +: 8] = i_wdata[8*(b & (int'(w_bytes) - 1)) +: 8];
        end
    end

    // Field width is clamped so an illegal dword size on a 32-bit bus stays in range.
    assign w_shifted = i_din >> {i_off, 3'b000};
    assign w_fbits   = {w_bytes, 3'b000};
    assign w_fbits_c = (w_fbits > 7'(DATA_W)) ? 7'(DATA_W) : w_fbits;
    assign w_msb     = IDX_W'(w_fbits_c - 7'd1);
    assign w_sign    = i_sign_ext & w_shifted[w_msb];

    always_comb begin
        o_load_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            o_load_ext[i] = (7'(i) < w_fbits_c) ? w_shifted[i] : w_sign;
        end
    end

endmodule

// File: rtl/mcpu_bus_unit.sv
// Load/store bus unit between the CPU controller and the MIO bus: latches a request,
// runs one bus cycle with a bounded wait, and reports completion or an error.
module mcpu_bus_unit
    import mcpu_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(DATA_W / 8),
    localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err_align,
    output logic              err_timeout,
    output logic              CPU_MIO,
    output logic              mem_w,
    output logic [ADDR_W-1:0] Addr_out,
    output logic [DATA_W-1:0] Data_out,
    output logic [NB-1:0]     byte_en,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              MIO_ready,
    output state_e            o_dbg_state
);

    state_e            r_state;
    state_e            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_sign_ext;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_to_err;
    logic [2:0]        w_req_mask;
    logic              w_req_bad;
    logic              w_tmo;
    logic              w_acc;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_rep;
    logic [DATA_W-1:0] w_load_ext;

    // Alignment is judged on the live request so a bad access never reaches the bus.
    assign w_req_mask = 3'(size_bytes(size) - 4'd1);
    assign w_req_bad  = ((size == SZ_DWORD) && (DATA_W != 64)) || (|(addr[2:0] & w_req_mask));
    assign w_tmo      = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req) w_next = w_req_bad ? ERR : ACCESS;
            ACCESS: begin
                if (MIO_ready)  w_next = DONE;
                else if (w_tmo) w_next = ERR;
            end
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_to_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we       <= we;
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_addr     <= addr;
                        r_wdata    <= wdata;
                        r_cnt      <= '0;
                        r_to_err   <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (MIO_ready) begin
                        if (!r_we) r_rdata <= w_load_ext;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_tmo) r_to_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mcpu_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_size     (r_size),
        .i_off      (r_addr[OFF_W-1:0]),
        .i_sign_ext (r_sign_ext),
        .i_wdata    (r_wdata),
        .i_din      (Data_in),
        .o_byte_en  (w_be),
        .o_data_rep (w_rep),
        .o_load_ext (w_load_ext)
    );

    // Bus outputs decode straight from state so an async reset drops them at once.
    assign w_acc       = (r_state == ACCESS);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE) || (r_state == ERR);
    assign err_align   = (r_state == ERR) && !r_to_err;
    assign err_timeout = (r_state == ERR) && r_to_err;
    assign CPU_MIO     = w_acc;
    assign mem_w       = w_acc & r_we;
    assign Addr_out    = w_acc ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign Data_out    = w_acc ? w_rep : '0;
    assign byte_en     = w_acc ? w_be : '0;
    assign rdata       = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mcpu_bus_unit.sv
// Bench for mcpu_bus_unit: a 32-bit and a 64-bit instance (both TIMEOUT=4), directed
// vector table, randomized accesses against a reference model, and a mid-access reset.
module tb_mcpu_bus_unit;
    localparam int TMO = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        req32, req64, we_i, sx_i, ready_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i;
    logic [63:0] wdata_i, din_i;

    logic        busy32, done32, ea32, et32, mio32, mw32;
    logic [31:0] rdata32, ao32, dout32;
    logic [3:0]  be32;
    logic [1:0]  dbg32;
    logic        busy64, done64, ea64, et64, mio64, mw64;
    logic [63:0] rdata64, dout64;
    logic [31:0] ao64;
    logic [7:0]  be64;
    logic [1:0]  dbg64;

    mcpu_bus_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) u_dut32 (
        .clk(clk), .reset(reset), .req(req32), .we(we_i), .size(size_i), .sign_ext(sx_i),
        .addr(addr_i), .wdata(wdata_i[31:0]), .busy(busy32), .done(done32), .rdata(rdata32),
        .err_align(ea32), .err_timeout(et32), .CPU_MIO(mio32), .mem_w(mw32), .Addr_out(ao32),
        .Data_out(dout32), .byte_en(be32), .Data_in(din_i[31:0]), .MIO_ready(ready_i),
        .o_dbg_state(dbg32)
    );

    mcpu_bus_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) u_dut64 (
        .clk(clk), .reset(reset), .req(req64), .we(we_i), .size(size_i), .sign_ext(sx_i),
        .addr(addr_i), .wdata(wdata_i), .busy(busy64), .done(done64), .rdata(rdata64),
        .err_align(ea64), .err_timeout(et64), .CPU_MIO(mio64), .mem_w(mw64), .Addr_out(ao64),
        .Data_out(dout64), .byte_en(be64), .Data_in(din_i), .MIO_ready(ready_i),
        .o_dbg_state(dbg64)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_rd32, exp_rd64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] m_mask(input int nb);
        return (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    endfunction

    function automatic logic [63:0] m_rdata(input bit w64, input logic [1:0] sz, input bit sx,
                                            input logic [31:0] ad, input logic [63:0] din);
        int nb    = 1 << sz;
        int lanes = w64 ? 8 : 4;
        int off   = int'(ad) % lanes;
        logic [63:0] src = w64 ? din : (din & 64'hFFFF_FFFF);
        logic [63:0] v   = (src >> (8 * off)) & m_mask(nb);
        if (sx && v[8*nb-1]) v = v | ~m_mask(nb);
        return w64 ? v : (v & 64'hFFFF_FFFF);
    endfunction

    function automatic logic [63:0] m_dout(input bit w64, input logic [1:0] sz, input logic [63:0] wd);
        int nb    = 1 << sz;
        int lanes = w64 ? 8 : 4;
        logic [63:0] r = '0;
        for (int k = 0; k < lanes / nb; k++) r = r + ((wd & m_mask(nb)) << (8 * nb * k));
        return r;
    endfunction

    // ---------------- driver ----------------
    int          a_done_cyc, a_mio_cyc;
    logic        a_ea, a_et, a_mw, a_post;
    logic [63:0] a_rd, a_be, a_ao, a_dout;

    task automatic do_access(input bit w64, input bit we, input logic [1:0] sz, input bit sx,
                             input logic [31:0] ad, input logic [63:0] wd, input logic [63:0] din,
                             input int rdy);
        int acc = 0;
        @(negedge clk);
        we_i = we; size_i = sz; sx_i = sx; addr_i = ad; wdata_i = wd; ready_i = 1'b0;
        if (w64) req64 = 1'b1; else req32 = 1'b1;
        @(negedge clk);
        req32 = 1'b0; req64 = 1'b0;
        addr_i = $urandom; wdata_i = {$urandom, $urandom};
        a_done_cyc = -1; a_mio_cyc = 0; a_ea = 0; a_et = 0; a_mw = 0;
        a_be = '0; a_ao = '0; a_dout = '0; a_rd = '0;
        for (int c = 1; c <= 40; c++) begin
            if (w64 ? done64 : done32) begin
                a_done_cyc = c;
                a_ea = w64 ? ea64 : ea32;
                a_et = w64 ? et64 : et32;
                a_rd = w64 ? rdata64 : {32'd0, rdata32};
                break;
            end
            if (w64 ? mio64 : mio32) begin
                if (acc == 0) begin
                    a_be   = w64 ? {56'd0, be64} : {60'd0, be32};
                    a_ao   = w64 ? {32'd0, ao64} : {32'd0, ao32};
                    a_dout = w64 ? dout64 : {32'd0, dout32};
                    a_mw   = w64 ? mw64 : mw32;
                end
                ready_i = (acc == rdy);
                din_i   = ready_i ? din : {$urandom, $urandom};
                acc++;
                a_mio_cyc++;
            end else begin
                ready_i = 1'b0;
            end
            @(negedge clk);
        end
        ready_i = 1'b0;
        @(negedge clk);
        a_post = w64 ? (done64 | busy64) : (done32 | busy32);
    endtask

    task automatic verify(input string tag, input bit w64, input bit we, input int exp_err,
                          input int exp_done, input logic [63:0] exp_rd, input logic [63:0] exp_be,
                          input logic [63:0] exp_ao, input logic [63:0] exp_dout);
        check({tag, ".done_cycle"}, 64'(a_done_cyc), 64'(exp_done));
        check({tag, ".err_align"}, 64'(a_ea), 64'(exp_err == 1));
        check({tag, ".err_timeout"}, 64'(a_et), 64'(exp_err == 2));
        check({tag, ".mio_cycles"}, 64'(a_mio_cyc), 64'((exp_err == 1) ? 0 : exp_done - 1));
        check({tag, ".rdata"}, a_rd, exp_rd);
        check({tag, ".idle_after"}, 64'(a_post), 64'd0);
        if (exp_err != 1) begin
            check({tag, ".byte_en"}, a_be, exp_be);
            check({tag, ".addr_out"}, a_ao, exp_ao);
            check({tag, ".mem_w"}, 64'(a_mw), 64'(we));
            if (we) check({tag, ".data_out"}, a_dout, w64 ? exp_dout : (exp_dout & 64'hFFFF_FFFF));
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          w64;
        bit          we;
        logic [1:0]  sz;
        bit          sx;
        logic [31:0] ad;
        logic [63:0] wd;
        logic [63:0] din;
        int          rdy;
        int          exp_err;
        int          exp_done;
        logic [63:0] exp_rd;
        logic [63:0] exp_be;
        logic [63:0] exp_ao;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [63:0] er;
        reset = 1'b1; req32 = 0; req64 = 0; we_i = 0; sx_i = 0; ready_i = 0;
        size_i = 2'b00; addr_i = '0; wdata_i = '0; din_i = '0;
        exp_rd32 = '0; exp_rd64 = '0;

        vecs[0]  = '{0, 0, 2'd0, 1, 32'h1003, 64'h0, 64'h80FF_FF00, 0, 0, 2, 64'hFFFF_FF80, 64'h8, 64'h1000, 64'h0};
        vecs[1]  = '{0, 1, 2'd1, 0, 32'h2002, 64'h0000_BEEF, 64'h0, 3, 0, 5, 64'h0, 64'hC, 64'h2000, 64'hBEEF_BEEF};
        vecs[2]  = '{0, 0, 2'd2, 0, 32'h0006, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0};
        vecs[3]  = '{0, 0, 2'd3, 0, 32'h0000, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0};
        vecs[4]  = '{0, 0, 2'd2, 0, 32'h0000, 64'h0, 64'h0, 99, 2, 6, 64'h0, 64'hF, 64'h0, 64'h0};
        vecs[5]  = '{0, 0, 2'd2, 0, 32'h0010, 64'h0, 64'h1234_5678, 4, 0, 6, 64'h1234_5678, 64'hF, 64'h10, 64'h0};
        vecs[6]  = '{1, 0, 2'd3, 0, 32'h0008, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 2, 64'h1122_3344_5566_7788, 64'hFF, 64'h8, 64'h0};
        vecs[7]  = '{1, 0, 2'd1, 0, 32'h000E, 64'h0, 64'h9ABC_0000_0000_0000, 0, 0, 2, 64'h9ABC, 64'hC0, 64'h8, 64'h0};
        vecs[8]  = '{1, 1, 2'd0, 0, 32'h0005, 64'hA5, 64'h0, 1, 0, 3, 64'h0, 64'h20, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[9]  = '{0, 0, 2'd1, 1, 32'h0002, 64'h0, 64'h8001_0000, 2, 0, 4, 64'hFFFF_8001, 64'hC, 64'h0, 64'h0};
        vecs[10] = '{1, 0, 2'd2, 1, 32'h0004, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 2, 64'hFFFF_FFFF_8000_0000, 64'hF0, 64'h0, 64'h0};
        vecs[11] = '{0, 0, 2'd1, 0, 32'h0001, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0};
        vecs[12] = '{1, 0, 2'd2, 0, 32'h0002, 64'h0, 64'h0, 0, 1, 1, 64'h0, 64'h0, 64'h0, 64'h0};
        vecs[13] = '{0, 1, 2'd0, 0, 32'h0001, 64'hFFFF_FF5A, 64'h0, 0, 0, 2, 64'h0, 64'h2, 64'h0, 64'h5A5A_5A5A};

        // Reset state of both instances.
        #2;
        check("rst.ctrl32", {58'd0, busy32, done32, ea32, et32, mio32, mw32}, 64'd0);
        check("rst.ctrl64", {58'd0, busy64, done64, ea64, et64, mio64, mw64}, 64'd0);
        check("rst.rdata32", {32'd0, rdata32}, 64'd0);
        check("rst.rdata64", rdata64, 64'd0);
        check("rst.bus32", {ao32, dout32} | {60'd0, be32}, 64'd0);
        check("rst.bus64", dout64 | {32'd0, ao64} | {56'd0, be64}, 64'd0);
        check("rst.state", {60'd0, dbg32, dbg64}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_access(vecs[i].w64, vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].ad,
                      vecs[i].wd, vecs[i].din, vecs[i].rdy);
            if (vecs[i].we || vecs[i].exp_err != 0) er = vecs[i].w64 ? exp_rd64 : exp_rd32;
            else er = vecs[i].exp_rd;
            if (vecs[i].w64) exp_rd64 = er; else exp_rd32 = er;
            verify($sformatf("vec%0d", i), vecs[i].w64, vecs[i].we, vecs[i].exp_err,
                   vecs[i].exp_done, er, vecs[i].exp_be, vecs[i].exp_ao, vecs[i].exp_dout);
        end

        // Randomized accesses against the reference model.
        for (int i = 0; i < 150; i++) begin
            bit          w64 = 1'($urandom_range(0, 1));
            bit          we  = 1'($urandom_range(0, 1));
            bit          sx  = 1'($urandom_range(0, 1));
            logic [1:0]  sz  = 2'($urandom_range(0, 3));
            int          nb  = 1 << sz;
            int          lanes = w64 ? 8 : 4;
            logic [31:0] ad  = 32'($urandom_range(0, 255));
            logic [63:0] wd  = {$urandom, $urandom};
            logic [63:0] din = {$urandom, $urandom};
            int          rdy = $urandom_range(0, 6);
            int          e_err, e_done;
            bit          bad;
            if ($urandom_range(0, 3) != 0) ad = ad - (ad % nb);
            bad = (sz == 2'd3 && !w64) || ((int'(ad) % nb) != 0);
            if (bad)            begin e_err = 1; e_done = 1; end
            else if (rdy > TMO) begin e_err = 2; e_done = TMO + 2; end
            else                begin e_err = 0; e_done = rdy + 2; end
            er = w64 ? exp_rd64 : exp_rd32;
            if (e_err == 0 && !we) er = m_rdata(w64, sz, sx, ad, din);
            if (w64) exp_rd64 = er; else exp_rd32 = er;
            do_access(w64, we, sz, sx, ad, wd, din, rdy);
            verify($sformatf("rnd%0d", i), w64, we, e_err, e_done, er,
                   64'(((1 << nb) - 1) << (int'(ad) % lanes)) & (w64 ? 64'hFF : 64'hF),
                   64'(ad - 32'(int'(ad) % lanes)), m_dout(w64, sz, wd));
        end

        // Reset asserted in the second ACCESS cycle of a store.
        begin
            bit seen_done = 0;
            @(negedge clk);
            we_i = 1; size_i = 2'd2; sx_i = 0; addr_i = 32'h40; wdata_i = 64'hCAFE_F00D;
            ready_i = 0; req32 = 1;
            @(negedge clk);
            req32 = 0;
            check("rstmid.mio_c1", 64'(mio32), 64'd1);
            @(negedge clk);
            check("rstmid.mio_c2", 64'(mio32), 64'd1);
            check("rstmid.mw_c2", 64'(mw32), 64'd1);
            reset = 1'b1;
            #1;
            check("rstmid.mio_async", 64'(mio32), 64'd0);
            check("rstmid.mw_async", 64'(mw32), 64'd0);
            check("rstmid.busy", 64'(busy32), 64'd0);
            repeat (3) begin
                @(negedge clk);
                if (done32 || done64) seen_done = 1;
            end
            reset = 1'b0;
            @(negedge clk);
            if (done32) seen_done = 1;
            check("rstmid.no_done", 64'(seen_done), 64'd0);
            check("rstmid.rdata_cleared", {32'd0, rdata32}, 64'd0);
            exp_rd32 = '0; exp_rd64 = '0;
            do_access(0, 0, 2'd2, 0, 32'h44, 64'h0, 64'h0123_4567, 1);
            exp_rd32 = 64'h0123_4567;
            verify("rstmid.after", 0, 0, 0, 3, exp_rd32, 64'hF, 64'h44, 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
